regs_dbg_master: RTL and testbench
==================================

Name: regs_dbg_master

Overview:
- Debug initiator for the 32x8 CPU register file; drives its write port (write/wd/wdata) and one read port (address out, data in).
- Accepts a byte command stream (valid/ready): single-register write, single-register read, full 32-register dump.
- Returns read data on a byte response stream (valid/ready).
- Raises cpu_halt while a command is in progress, so the top level can mux the core's register-file access off.

Parameters:
ADDR_W, 5, register address width
DATA_W, 8, register data width; also command/response byte width
NUM_REGS, 32, registers covered by DUMP; must equal 2**ADDR_W

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous reset, active-low
cmd_valid  input  1  command byte valid
cmd_data  input  8  command byte
cmd_ready  output  1  command byte accepted when cmd_valid & cmd_ready
rsp_valid  output  1  response byte valid
rsp_data  output  8  response byte
rsp_ready  input  1  response byte consumed when rsp_valid & rsp_ready
reg_write  output  1  register-file write strobe
reg_wd  output  5  register-file write address
reg_wdata  output  8  register-file write data
reg_ra  output  5  register-file read address
reg_rdata  input  8  register-file read data; combinational from reg_ra
cpu_halt  output  1  high whenever state != IDLE
err  output  1  sticky error flag

Behaviour:
- Reset: clk and rst_n as decided; asynchronous, active-low. All outputs 0, state IDLE, partial command discarded. Same on reset mid-command, including mid-DUMP.
- Opcode byte: [7:6] op, [5] reserved, [4:0] addr.
  - 00 NOP: consumed, no action.
  - 01 WRITE: next byte is data.
  - 10 READ: returns one response byte.
  - 11 DUMP: addr ignored; returns 32 bytes, r0..r31.
- Reserved bit set: byte consumed; err set (sticky until reset); no register access; stay IDLE.
- States: IDLE, GET_DATA, WR, RD, RSP, DMP_RD, DMP_RSP.
- IDLE: cmd_ready=1. On accept:
  - WRITE -> GET_DATA, address latched.
  - READ -> RD.
  - DUMP -> DMP_RD, index=0.
  - NOP or error -> IDLE.
- GET_DATA: cmd_ready=1; data byte accepted -> WR.
- WR: exactly one cycle.
  - reg_write=1; reg_wd=latched address; reg_wdata=latched data.
  - -> IDLE, or -> RD when the optional feature is enabled.
- RD: one cycle; reg_ra=address; reg_rdata captured into the response register at the clock edge; -> RSP.
- RSP: rsp_valid=1, rsp_data stable until accepted; on accept -> IDLE.
- DMP_RD: reg_ra=index; capture; -> DMP_RSP.
- DMP_RSP: rsp_valid=1. On accept:
  - index==NUM_REGS-1 -> IDLE.
  - Otherwise index+1 -> DMP_RD.
  - Index is 5-bit; no wrap beyond 31.
- cmd_ready=0 in all states except IDLE and GET_DATA. The command stream is back-pressured during WR, RD, RSP and DUMP.
- Latency:
  - WRITE: data byte accepted on cycle N -> reg_write on cycle N+1 -> cmd_ready on N+2.
  - READ: opcode accepted on N -> rsp_valid on N+2.
  - DUMP: minimum 2 cycles per byte.
- rsp_valid never deasserts without a handshake. rsp_ready held low stalls indefinitely with no data change.
- Outside WR, reg_write=0 and reg_wd/reg_wdata hold their last values. reg_ra=0 when not in RD/DMP_RD.
- cpu_halt asserts the cycle after opcode acceptance (registered from state), deasserts on return to IDLE.
- Writes to r0 are permitted.
- Data read is the value present during the RD cycle. A write the same cycle is not bypassed.

Optional Feature:
- Macro: REGS_DBG_WRITE_ECHO_EN.
- Defined: after WR, the FSM enters RD with the same address and returns the read-back byte as one response. This confirms the write.
- Undefined: WRITE produces no response; WR returns to IDLE.

Test Plan:
- Reset mid-DUMP, after 5 bytes -> all outputs 0, cmd_ready=1 after release; next READ of r3 returns the register-file value, no stale DUMP bytes.
- WRITE 0x43, 0xA5 -> single reg_write pulse with reg_wd=3, reg_wdata=0xA5. Then READ 0x83 -> rsp_data=0xA5 exactly 2 cycles after opcode accept.
- Preload r0..r31 with 0x10+i; DUMP 0xC0 with rsp_ready random 50% -> 32 bytes 0x10..0x2F in order, none dropped or duplicated, cpu_halt high throughout.
- Byte 0x25 (reserved bit set) -> err=1 and stays set; no reg_write; following READ 0x83 still serviced normally.
- READ with rsp_ready=0 for 20 cycles -> rsp_valid and rsp_data stable, cmd_ready=0; released -> one accept, back to IDLE.
- With REGS_DBG_WRITE_ECHO_EN: WRITE 0x5F, 0x3C -> reg_write to r31, then response byte 0x3C. Without the macro: no response.

Source files
------------

// File: rtl/regs_dbg_master.sv
// Debug initiator for the CPU register file: byte commands in, read bytes out, halts the core while busy.
// Optional REGS_DBG_WRITE_ECHO_EN: a WRITE is followed by a read-back of the same register as one response.
module regs_dbg_master #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              cmd_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  input  logic              rsp_ready,
  output logic              reg_write,
  output logic [ADDR_W-1:0] reg_wd,
  output logic [DATA_W-1:0] reg_wdata,
  output logic [ADDR_W-1:0] reg_ra,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              cpu_halt,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, GET_DATA, WR, RD, RSP, DMP_RD, DMP_RSP} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] reg_wd_q, reg_wd_d;
  logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] reg_ra_q, reg_ra_d;
  logic              cpu_halt_q, cpu_halt_d;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    idx_d       = idx_q;
    err_d       = err_q;
    reg_wd_d    = reg_wd_q;
    reg_wdata_d = reg_wdata_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          if (cmd_data[5]) begin
            err_d = 1'b1;
          end else begin
            case (cmd_data[7:6])
              2'b01: begin
                addr_d  = cmd_data[ADDR_W-1:0];
                state_d = GET_DATA;
              end
              2'b10: begin
                addr_d  = cmd_data[ADDR_W-1:0];
                state_d = RD;
              end
              2'b11: begin
                idx_d   = '0;
                state_d = DMP_RD;
              end
              default: state_d = IDLE;
            endcase
          end
        end
      end
      GET_DATA: begin
        if (cmd_valid && cmd_ready_q) begin
          reg_wd_d    = addr_q;
          reg_wdata_d = cmd_data;
          state_d     = WR;
        end
      end
      WR: begin
`ifdef REGS_DBG_WRITE_ECHO_EN
        state_d = RD;
`else
        state_d = IDLE;
`endif
      end
      RD: begin
        rsp_data_d = reg_rdata;
        state_d    = RSP;
      end
      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end
      DMP_RD: begin
        rsp_data_d = reg_rdata;
        state_d    = DMP_RSP;
      end
      DMP_RSP: begin
        if (rsp_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = DMP_RD;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered yet line up with it.
    cmd_ready_d = (state_d == IDLE) || (state_d == GET_DATA);
    rsp_valid_d = (state_d == RSP) || (state_d == DMP_RSP);
    reg_write_d = (state_d == WR);
    cpu_halt_d  = (state_d != IDLE);
    reg_ra_d    = (state_d == RD) ? addr_d : ((state_d == DMP_RD) ? idx_d : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      idx_q       <= '0;
      err_q       <= 1'b0;
      reg_wd_q    <= '0;
      reg_wdata_q <= '0;
      rsp_data_q  <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      reg_write_q <= 1'b0;
      reg_ra_q    <= '0;
      cpu_halt_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      reg_wd_q    <= reg_wd_d;
      reg_wdata_q <= reg_wdata_d;
      rsp_data_q  <= rsp_data_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      reg_write_q <= reg_write_d;
      reg_ra_q    <= reg_ra_d;
      cpu_halt_q  <= cpu_halt_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign reg_write = reg_write_q;
  assign reg_wd    = reg_wd_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_ra    = reg_ra_q;
  assign cpu_halt  = cpu_halt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_regs_dbg_master.sv
// Self-checking bench for regs_dbg_master with a behavioural register-file model and response scoreboard.
module tb_regs_dbg_master;

`ifdef REGS_DBG_WRITE_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_ready;
  logic       fix_ready = 1'b1;
  logic       rand_ready = 1'b0;
  logic       rnd_bit = 1'b0;
  logic       reg_write;
  logic [4:0] reg_wd;
  logic [7:0] reg_wdata;
  logic [4:0] reg_ra;
  logic [7:0] reg_rdata;
  logic       cpu_halt;
  logic       err;

  int pass_cnt = 0;
  int total_cnt = 0;

  regs_dbg_master dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .reg_write(reg_write), .reg_wd(reg_wd), .reg_wdata(reg_wdata),
    .reg_ra(reg_ra), .reg_rdata(reg_rdata),
    .cpu_halt(cpu_halt), .err(err)
  );

  always #5 clk = ~clk;

  assign rsp_ready = rand_ready ? rnd_bit : fix_ready;
  always @(negedge clk) rnd_bit <= ($urandom_range(0, 1) == 1);

  // Register file the master talks to; the bench can bulk-load it while the master is idle.
  logic [7:0] rf_mem [32];
  logic [7:0] load_mem [32];
  logic       load_req = 1'b0;

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= load_mem[i];
    end else if (reg_write) begin
      rf_mem[reg_wd] <= reg_wdata;
    end
  end
  assign reg_rdata = rf_mem[reg_ra];

  // Response capture, write-strobe counting and hold-while-stalled checking.
  logic [7:0] got_mem [2048];
  int         got_cnt = 0;
  int         wr_cnt = 0;
  int         hold_viol = 0;
  logic       stall_prev = 1'b0;
  logic [7:0] stall_data = 8'h00;

  always @(posedge clk) begin
    if (rst_n && rsp_valid && rsp_ready && got_cnt < 2048) begin
      got_mem[got_cnt[10:0]] <= rsp_data;
      got_cnt <= got_cnt + 1;
    end
    if (rst_n && reg_write) wr_cnt <= wr_cnt + 1;
    if (rst_n && stall_prev && (!rsp_valid || rsp_data != stall_data)) hold_viol <= hold_viol + 1;
    stall_prev <= rst_n && rsp_valid && !rsp_ready;
    stall_data <= rsp_data;
  end

  typedef struct {
    logic [7:0] op;
    logic [7:0] wdata;
    bit         has_data;
    int         exp_n;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t vecs [7];
  logic [7:0] mdl [32];
  logic [7:0] exp_q [$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic sendByte(input logic [7:0] b);
    bit ok = 1'b0;
    cmd_valid = 1'b1;
    cmd_data  = b;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk);
      if (cmd_ready) ok = 1'b1;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    if (!ok) checkOutput("cmd_accept_timeout", 0, 1);
  endtask

  task automatic waitIdle();
    bit ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (!cpu_halt && !rsp_valid) ok = 1'b1;
    end
    if (!ok) checkOutput("idle_timeout", 0, 1);
  endtask

  task automatic applyStimulus(input logic [7:0] op, input logic [7:0] d, input bit has_d);
    sendByte(op);
    if (has_d) sendByte(d);
    waitIdle();
  endtask

  task automatic loadRegs();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base, wr0, mism, kind;
    bit stable, halt_ok, ok;
    logic [4:0] a;
    logic [7:0] d;

    vecs[0] = '{8'h43, 8'hA5, 1'b1, ECHO ? 1 : 0, 8'hA5};
    vecs[1] = '{8'h83, 8'h00, 1'b0, 1, 8'hA5};
    vecs[2] = '{8'h5F, 8'h3C, 1'b1, ECHO ? 1 : 0, 8'h3C};
    vecs[3] = '{8'h9F, 8'h00, 1'b0, 1, 8'h3C};
    vecs[4] = '{8'h00, 8'h00, 1'b0, 0, 8'h00};
    vecs[5] = '{8'h40, 8'h77, 1'b1, ECHO ? 1 : 0, 8'h77};
    vecs[6] = '{8'h80, 8'h00, 1'b0, 1, 8'h77};

    for (int i = 0; i < 32; i++) load_mem[i] = 8'h00;
    @(negedge clk);
    loadRegs();
    @(negedge clk);
    checkOutput("reset_cmd_ready", 32'(cmd_ready), 0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 0);
    checkOutput("reset_cpu_halt", 32'(cpu_halt), 0);
    checkOutput("reset_reg_write", 32'(reg_write), 0);
    checkOutput("reset_reg_ra", 32'(reg_ra), 0);
    checkOutput("reset_reg_wd", 32'(reg_wd), 0);
    checkOutput("reset_reg_wdata", 32'(reg_wdata), 0);
    checkOutput("reset_rsp_data", 32'(rsp_data), 0);
    checkOutput("reset_err", 32'(err), 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_reset", 32'(cmd_ready), 1);

    // WRITE r3 = 0xA5 with cycle-exact strobe timing.
    wr0 = wr_cnt; base = got_cnt;
    sendByte(8'h43);
    sendByte(8'hA5);
    checkOutput("wr_strobe", 32'(reg_write), 1);
    checkOutput("wr_addr", 32'(reg_wd), 3);
    checkOutput("wr_data", 32'(reg_wdata), 'hA5);
    checkOutput("wr_halt", 32'(cpu_halt), 1);
    @(negedge clk);
    checkOutput("wr_strobe_end", 32'(reg_write), 0);
    checkOutput("wr_ready_next", 32'(cmd_ready), ECHO ? 0 : 1);
    checkOutput("wr_hold_addr", 32'(reg_wd), 3);
    waitIdle();
    checkOutput("wr_pulse_count", 32'(wr_cnt - wr0), 1);
    checkOutput("wr_rsp_count", 32'(got_cnt - base), ECHO ? 1 : 0);
    if (got_cnt > base) checkOutput("wr_echo_byte", 32'(got_mem[base]), 'hA5);

    // READ r3 with the response stalled for 20 cycles.
    fix_ready = 1'b0; base = got_cnt;
    sendByte(8'h83);
    checkOutput("rd_valid_n1", 32'(rsp_valid), 0);
    checkOutput("rd_ready_n1", 32'(cmd_ready), 0);
    checkOutput("rd_ra_n1", 32'(reg_ra), 3);
    @(negedge clk);
    checkOutput("rd_valid_n2", 32'(rsp_valid), 1);
    checkOutput("rd_data_n2", 32'(rsp_data), 'hA5);
    checkOutput("rd_ra_idle", 32'(reg_ra), 0);
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data != 8'hA5 || cmd_ready || !cpu_halt) stable = 1'b0;
    end
    checkOutput("rd_stall_stable", 32'(stable), 1);
    checkOutput("rd_stall_no_accept", 32'(got_cnt - base), 0);
    fix_ready = 1'b1;
    @(negedge clk);
    checkOutput("rd_released_valid", 32'(rsp_valid), 0);
    checkOutput("rd_released_halt", 32'(cpu_halt), 0);
    checkOutput("rd_released_ready", 32'(cmd_ready), 1);
    checkOutput("rd_accept_count", 32'(got_cnt - base), 1);
    checkOutput("rd_accept_byte", 32'(got_mem[base]), 'hA5);

    // Reserved bit set: sticky error, no access, following READ still works.
    wr0 = wr_cnt;
    sendByte(8'h25);
    checkOutput("err_set", 32'(err), 1);
    checkOutput("err_no_halt", 32'(cpu_halt), 0);
    waitIdle();
    checkOutput("err_no_write", 32'(wr_cnt - wr0), 0);
    base = got_cnt;
    applyStimulus(8'h83, 8'h00, 1'b0);
    checkOutput("err_read_count", 32'(got_cnt - base), 1);
    checkOutput("err_read_byte", 32'(got_mem[base]), 'hA5);
    checkOutput("err_sticky", 32'(err), 1);

    // Full DUMP with random response back-pressure.
    for (int i = 0; i < 32; i++) load_mem[i] = 8'(16 + i);
    loadRegs();
    base = got_cnt; rand_ready = 1'b1;
    sendByte(8'hC0);
    halt_ok = 1'b1; ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (got_cnt - base >= 32) ok = 1'b1;
      else if (!cpu_halt) halt_ok = 1'b0;
    end
    checkOutput("dump_halt_throughout", 32'(halt_ok), 1);
    waitIdle();
    rand_ready = 1'b0;
    checkOutput("dump_count", 32'(got_cnt - base), 32);
    mism = 0;
    for (int i = 0; i < 32; i++) if (got_mem[base + i] !== 8'(16 + i)) mism++;
    checkOutput("dump_order", 32'(mism), 0);

    // Reset in the middle of a DUMP after five bytes.
    base = got_cnt; rand_ready = 1'b1;
    sendByte(8'hC0);
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      if (got_cnt - base >= 5) ok = 1'b1;
      else @(negedge clk);
    end
    checkOutput("middump_bytes", 32'(got_cnt - base), 5);
    rst_n = 1'b0;
    #1;
    checkOutput("middump_rsp_valid", 32'(rsp_valid), 0);
    checkOutput("middump_halt", 32'(cpu_halt), 0);
    checkOutput("middump_ra", 32'(reg_ra), 0);
    checkOutput("middump_rsp_data", 32'(rsp_data), 0);
    checkOutput("middump_err", 32'(err), 0);
    checkOutput("middump_ready", 32'(cmd_ready), 0);
    @(negedge clk);
    rand_ready = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("middump_ready_after", 32'(cmd_ready), 1);
    base = got_cnt;
    applyStimulus(8'h83, 8'h00, 1'b0);
    checkOutput("middump_read_count", 32'(got_cnt - base), 1);
    checkOutput("middump_read_byte", 32'(got_mem[base]), 'h13);

    // Table-driven command vectors.
    for (int v = 0; v < 7; v++) begin
      base = got_cnt;
      applyStimulus(vecs[v].op, vecs[v].wdata, vecs[v].has_data);
      checkOutput($sformatf("vec%0d_count", v), 32'(got_cnt - base), 32'(vecs[v].exp_n));
      if (vecs[v].exp_n > 0) checkOutput($sformatf("vec%0d_byte", v), 32'(got_mem[base]), 32'(vecs[v].exp_byte));
    end

    // Randomized commands against the behavioural register-file model.
    for (int i = 0; i < 32; i++) begin
      load_mem[i] = 8'($urandom);
      mdl[i] = load_mem[i];
    end
    loadRegs();
    exp_q.delete();
    base = got_cnt; rand_ready = 1'b1;
    for (int k = 0; k < 50; k++) begin
      kind = int'($urandom_range(0, 9));
      a = 5'($urandom_range(0, 31));
      d = 8'($urandom);
      if (kind < 4) begin
        applyStimulus({2'b01, 1'b0, a}, d, 1'b1);
        mdl[a] = d;
        if (ECHO) exp_q.push_back(d);
      end else if (kind < 8) begin
        applyStimulus({2'b10, 1'b0, a}, 8'h00, 1'b0);
        exp_q.push_back(mdl[a]);
      end else if (kind == 8) begin
        applyStimulus({2'b00, 1'b0, a}, 8'h00, 1'b0);
      end else begin
        applyStimulus({2'b11, 1'b0, a}, 8'h00, 1'b0);
        for (int i = 0; i < 32; i++) exp_q.push_back(mdl[i]);
      end
    end
    rand_ready = 1'b0;
    checkOutput("rand_rsp_count", 32'(got_cnt - base), 32'(exp_q.size()));
    mism = 0;
    for (int i = 0; i < exp_q.size(); i++) if (got_mem[base + i] !== exp_q[i]) mism++;
    checkOutput("rand_rsp_bytes", 32'(mism), 0);
    mism = 0;
    for (int i = 0; i < 32; i++) if (rf_mem[i] !== mdl[i]) mism++;
    checkOutput("rand_rf_contents", 32'(mism), 0);
    checkOutput("rsp_hold_violations", 32'(hold_viol), 0);
    checkOutput("final_err_clear", 32'(err), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
